// File: rtl/rob_alloc_queue.sv
// Reorder-buffer allocation/commit queue: dual in-order allocate, writeback completion,
// dual in-order commit with stale-PRF release, branch truncation and full flush.
module rob_alloc_queue #(
   parameter int unsigned ROB_DEPTH = 16,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned PRF_W     = 6,
   parameter int unsigned ARF_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr0_req,
   input  logic             instr1_req,
   input  logic [PRF_W-1:0] instr0_stale_rd,
   input  logic [PRF_W-1:0] instr1_stale_rd,
   input  logic             instr0_stale_rd_valid,
   input  logic             instr1_stale_rd_valid,
   input  logic [ARF_W-1:0] instr0_rd_arf,
   input  logic [ARF_W-1:0] instr1_rd_arf,
   input  logic [PRF_W-1:0] instr0_rd_prf,
   input  logic [PRF_W-1:0] instr1_rd_prf,
   input  logic [31:0]      instr0_pc,
   input  logic [31:0]      instr1_pc,
   input  logic             instr0_is_store_op,
   input  logic             instr1_is_store_op,
   output logic             rob_instr0_check_top,
   output logic             rob_instr1_check_top,
   output logic             rob_is_empty,
   output logic [TAG_W-1:0] instr0_rob_tag,
   output logic [TAG_W-1:0] instr1_rob_tag,
   input  logic             wb0_valid,
   input  logic             wb1_valid,
   input  logic [TAG_W-1:0] wb0_tag,
   input  logic [TAG_W-1:0] wb1_tag,
   input  logic             br_recover,
   input  logic [TAG_W-1:0] br_tag,
   input  logic             flush,
   output logic             recovery_no_copy,
   output logic [TAG_W-1:0] recovery_target_rob_tag,
   output logic             commit0_valid,
   output logic             commit1_valid,
   output logic [PRF_W-1:0] commit0_stale_rd,
   output logic [PRF_W-1:0] commit1_stale_rd,
   output logic             commit0_free,
   output logic             commit1_free,
   output logic [ARF_W-1:0] commit0_rd_arf,
   output logic [ARF_W-1:0] commit1_rd_arf,
   output logic [PRF_W-1:0] commit0_rd_prf,
   output logic [PRF_W-1:0] commit1_rd_prf,
   output logic             commit0_is_store,
   output logic             commit1_is_store
);

   localparam int unsigned PTR_W = TAG_W + 1;

   typedef struct packed {
      logic [PRF_W-1:0] stale_rd;
      logic             stale_valid;
      logic [ARF_W-1:0] rd_arf;
      logic [PRF_W-1:0] rd_prf;
      logic             is_store;
   } entry_t;

   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, count, tail1, br_tail;
   logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d;
   entry_t               pl_q [ROB_DEPTH];
   entry_t               pl_d [ROB_DEPTH];
   logic                 no_copy_q, no_copy_d;
   logic [TAG_W-1:0]     target_q, target_d;
   logic [TAG_W-1:0]     head_idx, head_idx1, br_off;
   logic                 alloc0, alloc1;
   entry_t               c0_e, c1_e;

   assign count                = tail_q - head_q;
   assign rob_instr0_check_top = count <= PTR_W'(ROB_DEPTH - 1);
   assign rob_instr1_check_top = count <= PTR_W'(ROB_DEPTH - 2);
   assign rob_is_empty         = count == '0;

   assign tail1          = tail_q + {{TAG_W{1'b0}}, instr0_req};
   assign instr0_rob_tag = tail_q[TAG_W-1:0];
   assign instr1_rob_tag = tail1[TAG_W-1:0];

   assign head_idx  = head_q[TAG_W-1:0];
   assign head_idx1 = head_idx + 1'b1;
   assign c0_e      = pl_q[head_idx];
   assign c1_e      = pl_q[head_idx1];

   assign commit0_valid    = valid_q[head_idx] & done_q[head_idx];
   assign commit1_valid    = commit0_valid & valid_q[head_idx1] & done_q[head_idx1];
   assign commit0_stale_rd = c0_e.stale_rd;
   assign commit1_stale_rd = c1_e.stale_rd;
   assign commit0_free     = commit0_valid & c0_e.stale_valid;
   assign commit1_free     = commit1_valid & c1_e.stale_valid;
   assign commit0_rd_arf   = c0_e.rd_arf;
   assign commit1_rd_arf   = c1_e.rd_arf;
   assign commit0_rd_prf   = c0_e.rd_prf;
   assign commit1_rd_prf   = c1_e.rd_prf;
   assign commit0_is_store = commit0_valid & c0_e.is_store;
   assign commit1_is_store = commit1_valid & c1_e.is_store;

   assign recovery_no_copy        = no_copy_q;
   assign recovery_target_rob_tag = target_q;

   assign alloc0 = instr0_req & rob_instr0_check_top;
   assign alloc1 = instr1_req & rob_instr1_check_top;

   // Branch offset from head gives the new tail, including its wrap bit.
   assign br_off  = br_tag - head_idx;
   assign br_tail = head_q + PTR_W'(br_off) + PTR_W'(1);

   always_comb begin
      valid_d   = valid_q;
      done_d    = done_q;
      pl_d      = pl_q;
      tail_d    = tail_q;
      no_copy_d = no_copy_q;
      target_d  = target_q;
      head_d    = head_q + {{TAG_W{1'b0}}, commit0_valid} + {{TAG_W{1'b0}}, commit1_valid};

      if (wb0_valid && valid_q[wb0_tag]) done_d[wb0_tag] = 1'b1;
      if (wb1_valid && valid_q[wb1_tag]) done_d[wb1_tag] = 1'b1;

      if (commit0_valid) begin
         valid_d[head_idx] = 1'b0;
         done_d[head_idx]  = 1'b0;
      end
      if (commit1_valid) begin
         valid_d[head_idx1] = 1'b0;
         done_d[head_idx1]  = 1'b0;
      end

      if (flush) begin
         valid_d   = '0;
         done_d    = '0;
         tail_d    = head_d;
         no_copy_d = 1'b0;
      end else if (br_recover) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            if (TAG_W'(TAG_W'(i) - head_idx) > br_off) begin
               valid_d[i] = 1'b0;
               done_d[i]  = 1'b0;
            end
         end
         tail_d    = br_tail;
         target_d  = br_tag;
         no_copy_d = tail_q == br_tail;
      end else begin
         if (alloc0) begin
            valid_d[instr0_rob_tag] = 1'b1;
            done_d[instr0_rob_tag]  = 1'b0;
            pl_d[instr0_rob_tag]    = '{instr0_stale_rd, instr0_stale_rd_valid, instr0_rd_arf,
                                        instr0_rd_prf, instr0_is_store_op};
         end
         if (alloc1) begin
            valid_d[instr1_rob_tag] = 1'b1;
            done_d[instr1_rob_tag]  = 1'b0;
            pl_d[instr1_rob_tag]    = '{instr1_stale_rd, instr1_stale_rd_valid, instr1_rd_arf,
                                        instr1_rd_prf, instr1_is_store_op};
         end
         tail_d = tail_q + {{TAG_W{1'b0}}, alloc0} + {{TAG_W{1'b0}}, alloc1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         valid_q   <= '0;
         done_q    <= '0;
         no_copy_q <= 1'b0;
         target_q  <= '0;
         for (int unsigned i = 0; i < ROB_DEPTH; i++) pl_q[i] <= '0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         no_copy_q <= no_copy_d;
         target_q  <= target_d;
         for (int unsigned i = 0; i < ROB_DEPTH; i++) pl_q[i] <= pl_d[i];
      end
   end

endmodule

// File: tb/tb_rob_alloc_queue.sv
// Directed self-checking bench for rob_alloc_queue: allocation, wrap, commit order,
// branch recovery and flush, with hand-computed expectations.
module tb_rob_alloc_queue;
   localparam int unsigned D = 16, TW = 4, PW = 6, AW = 5;

   logic          clk = 1'b0, rst = 1'b1;
   logic          instr0_req, instr1_req;
   logic [PW-1:0] instr0_stale_rd, instr1_stale_rd;
   logic          instr0_stale_rd_valid, instr1_stale_rd_valid;
   logic [AW-1:0] instr0_rd_arf, instr1_rd_arf;
   logic [PW-1:0] instr0_rd_prf, instr1_rd_prf;
   logic [31:0]   instr0_pc, instr1_pc;
   logic          instr0_is_store_op, instr1_is_store_op;
   logic          ct0, ct1, empty;
   logic [TW-1:0] tag0, tag1;
   logic          wb0_valid, wb1_valid;
   logic [TW-1:0] wb0_tag, wb1_tag;
   logic          br_recover, flush;
   logic [TW-1:0] br_tag;
   logic          no_copy;
   logic [TW-1:0] target;
   logic          c0v, c1v, c0f, c1f, c0s, c1s;
   logic [PW-1:0] c0_stale, c1_stale, c0_prf, c1_prf;
   logic [AW-1:0] c0_arf, c1_arf;

   int n_tests = 0;
   int n_fail  = 0;

   rob_alloc_queue #(.ROB_DEPTH(D), .TAG_W(TW), .PRF_W(PW), .ARF_W(AW)) dut (
      .clk(clk), .rst(rst),
      .instr0_req(instr0_req), .instr1_req(instr1_req),
      .instr0_stale_rd(instr0_stale_rd), .instr1_stale_rd(instr1_stale_rd),
      .instr0_stale_rd_valid(instr0_stale_rd_valid), .instr1_stale_rd_valid(instr1_stale_rd_valid),
      .instr0_rd_arf(instr0_rd_arf), .instr1_rd_arf(instr1_rd_arf),
      .instr0_rd_prf(instr0_rd_prf), .instr1_rd_prf(instr1_rd_prf),
      .instr0_pc(instr0_pc), .instr1_pc(instr1_pc),
      .instr0_is_store_op(instr0_is_store_op), .instr1_is_store_op(instr1_is_store_op),
      .rob_instr0_check_top(ct0), .rob_instr1_check_top(ct1), .rob_is_empty(empty),
      .instr0_rob_tag(tag0), .instr1_rob_tag(tag1),
      .wb0_valid(wb0_valid), .wb1_valid(wb1_valid), .wb0_tag(wb0_tag), .wb1_tag(wb1_tag),
      .br_recover(br_recover), .br_tag(br_tag), .flush(flush),
      .recovery_no_copy(no_copy), .recovery_target_rob_tag(target),
      .commit0_valid(c0v), .commit1_valid(c1v),
      .commit0_stale_rd(c0_stale), .commit1_stale_rd(c1_stale),
      .commit0_free(c0f), .commit1_free(c1f),
      .commit0_rd_arf(c0_arf), .commit1_rd_arf(c1_arf),
      .commit0_rd_prf(c0_prf), .commit1_rd_prf(c1_prf),
      .commit0_is_store(c0s), .commit1_is_store(c1s)
   );

   always #5 clk = ~clk;

   // A recovering branch must name a live entry.
   always @(posedge clk) begin
      if (!rst && br_recover) assert (dut.valid_q[br_tag]) else $error("illegal br_tag %0d", br_tag);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      instr0_req = 0; instr1_req = 0;
      instr0_stale_rd = '0; instr1_stale_rd = '0;
      instr0_stale_rd_valid = 0; instr1_stale_rd_valid = 0;
      instr0_rd_arf = '0; instr1_rd_arf = '0; instr0_rd_prf = '0; instr1_rd_prf = '0;
      instr0_pc = '0; instr1_pc = '0; instr0_is_store_op = 0; instr1_is_store_op = 0;
      wb0_valid = 0; wb1_valid = 0; wb0_tag = '0; wb1_tag = '0;
      br_recover = 0; br_tag = '0; flush = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Payload derived from a seed so expected commit fields are easy to compute.
   task automatic set_slot0(input int s);
      instr0_req = 1;
      instr0_stale_rd = PW'(s + 1); instr0_stale_rd_valid = s[0];
      instr0_rd_arf = AW'(s); instr0_rd_prf = PW'(s + 32);
      instr0_pc = 32'(s * 4); instr0_is_store_op = s[1];
   endtask

   task automatic set_slot1(input int s);
      instr1_req = 1;
      instr1_stale_rd = PW'(s + 1); instr1_stale_rd_valid = s[0];
      instr1_rd_arf = AW'(s); instr1_rd_prf = PW'(s + 32);
      instr1_pc = 32'(s * 4); instr1_is_store_op = s[1];
   endtask

   initial begin
      idle_inputs();
      do_reset();
      settle();
      check_eq("rst_empty", empty, 1);
      check_eq("rst_ct0", ct0, 1);
      check_eq("rst_ct1", ct1, 1);
      check_eq("rst_c0v", c0v, 0);
      check_eq("rst_c1v", c1v, 0);
      check_eq("rst_nocopy", no_copy, 0);
      check_eq("rst_target", target, 0);

      // Fill with eight dual allocations.
      for (int k = 0; k < 8; k++) begin
         set_slot0(2 * k); set_slot1(2 * k + 1);
         settle();
         check_eq("fill_tag0", tag0, 2 * k);
         check_eq("fill_tag1", tag1, 2 * k + 1);
         step();
      end
      settle();
      check_eq("full_ct0", ct0, 0);
      check_eq("full_ct1", ct1, 0);
      check_eq("full_empty", empty, 0);

      // Asynchronous reset mid-operation.
      rst = 1'b1;
      #1;
      check_eq("async_rst_empty", empty, 1);
      check_eq("async_rst_ct1", ct1, 1);
      do_reset();

      // count = 15, dual request: only slot0 allocates.
      for (int k = 0; k < 7; k++) begin
         set_slot0(2 * k); set_slot1(2 * k + 1); step();
      end
      set_slot0(14); step();
      set_slot0(15); set_slot1(16);
      settle();
      check_eq("c15_ct0", ct0, 1);
      check_eq("c15_ct1", ct1, 0);
      check_eq("c15_tag0", tag0, 15);
      step(); settle();
      check_eq("c16_ct0", ct0, 0);
      check_eq("c16_tail", tag0, 0);
      check_eq("c16_empty", empty, 0);

      // Out-of-order writeback, in-order dual commit.
      do_reset();
      set_slot0(0); set_slot1(1); step();
      set_slot0(2); step();
      wb0_valid = 1; wb0_tag = 2; wb1_valid = 1; wb1_tag = 1;
      settle(); check_eq("ooo_n_c0v", c0v, 0);
      step();
      wb0_valid = 1; wb0_tag = 0;
      settle(); check_eq("ooo_n1_c0v", c0v, 0);
      step(); settle();
      check_eq("ooo_n2_c0v", c0v, 1);
      check_eq("ooo_n2_c1v", c1v, 1);
      check_eq("ooo_n2_arf0", c0_arf, 0);
      check_eq("ooo_n2_arf1", c1_arf, 1);
      check_eq("ooo_n2_prf1", c1_prf, 33);
      step(); settle();
      check_eq("ooo_n3_c0v", c0v, 1);
      check_eq("ooo_n3_c1v", c1v, 0);
      check_eq("ooo_n3_arf0", c0_arf, 2);
      step(); settle();
      check_eq("ooo_empty", empty, 1);

      // Twenty singles wrap the tag space.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         set_slot0(k);
         settle();
         check_eq("wrap_tag", tag0, k % 16);
         step();
         wb0_valid = 1; wb0_tag = TW'(k % 16);
         settle();
         check_eq("wrap_nocommit", c0v, 0);
         step(); settle();
         check_eq("wrap_c0v", c0v, 1);
         check_eq("wrap_arf", c0_arf, k % 32);
         check_eq("wrap_free", c0f, k & 1);
         check_eq("wrap_stale", c0_stale, (k + 1) % 64);
         check_eq("wrap_store", c0s, (k >> 1) & 1);
         step();
      end
      settle();
      check_eq("wrap_empty", empty, 1);

      // Branch recovery with entries 3..9 live.
      do_reset();
      set_slot0(0); set_slot1(1); step();
      set_slot0(2); wb0_valid = 1; wb0_tag = 0; wb1_valid = 1; wb1_tag = 1; step();
      wb0_valid = 1; wb0_tag = 2; step();
      step();
      set_slot0(3); set_slot1(4); step();
      set_slot0(5); set_slot1(6); step();
      set_slot0(7); set_slot1(8); step();
      set_slot0(9); step();
      br_recover = 1; br_tag = 5; set_slot0(50); set_slot1(51);
      step(); settle();
      check_eq("br_tail", tag0, 6);
      check_eq("br_nocopy", no_copy, 0);
      check_eq("br_target", target, 5);
      check_eq("br_ct1", ct1, 1);
      br_recover = 1; br_tag = 5;
      step(); settle();
      check_eq("br2_nocopy", no_copy, 1);
      check_eq("br2_tail", tag0, 6);
      wb0_valid = 1; wb0_tag = 3; wb1_valid = 1; wb1_tag = 4; step();
      wb0_valid = 1; wb0_tag = 5; wb1_valid = 1; wb1_tag = 6;
      settle();
      check_eq("br_c0v", c0v, 1);
      check_eq("br_c1v", c1v, 1);
      check_eq("br_arf0", c0_arf, 3);
      check_eq("br_arf1", c1_arf, 4);
      step(); settle();
      check_eq("br_last_c0v", c0v, 1);
      check_eq("br_last_c1v", c1v, 0);
      check_eq("br_last_arf", c0_arf, 5);
      step(); settle();
      check_eq("br_empty", empty, 1);

      // Flush while head is done.
      do_reset();
      set_slot0(10); set_slot1(11); step();
      wb0_valid = 1; wb0_tag = 0; step();
      flush = 1; wb1_valid = 1; wb1_tag = 1; set_slot0(20); set_slot1(21);
      settle();
      check_eq("fl_c0v", c0v, 1);
      check_eq("fl_arf", c0_arf, 10);
      check_eq("fl_c1v", c1v, 0);
      step(); settle();
      check_eq("fl_empty", empty, 1);
      check_eq("fl_tail", tag0, 1);
      check_eq("fl_c0v_after", c0v, 0);
      check_eq("fl_nocopy", no_copy, 0);
      set_slot0(40); step(); settle();
      check_eq("fl_realloc_notdone", c0v, 0);
      wb0_valid = 1; wb0_tag = 1; step(); settle();
      check_eq("fl_realloc_c0v", c0v, 1);
      check_eq("fl_realloc_arf", c0_arf, 8);
      step(); settle();
      check_eq("fl_final_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rob_alloc_queue.md
Name: rob_alloc_queue

Overview:
Reorder-buffer allocation and commit queue for the dual-dispatch core, directly downstream of the rename/dispatch stage on its ROB channel. It accepts up to two in-order allocations per cycle and returns ROB tags. It records stale/new register mappings, marks entries complete from writeback, and commits up to two entries per cycle in order, releasing stale PRFs. It also performs branch-recovery truncation and full flush.

Parameters:
ROB_DEPTH, 16, number of entries (power of two, >=4)
TAG_W, 4, log2(ROB_DEPTH); width of a ROB tag
PRF_W, 6, physical register specifier width
ARF_W, 5, architectural register specifier width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr0_req / instr1_req  in  1  allocate request, slot 0 / slot 1
instr0_stale_rd, instr1_stale_rd  in  PRF_W  previous PRF mapping of rd
instr0_stale_rd_valid, instr1_stale_rd_valid  in  1  stale mapping must be freed at commit
instr0_rd_arf, instr1_rd_arf  in  ARF_W  architectural rd
instr0_rd_prf, instr1_rd_prf  in  PRF_W  newly allocated PRF
instr0_pc, instr1_pc  in  32  instruction PC
instr0_is_store_op, instr1_is_store_op  in  1  store marker
rob_instr0_check_top  out  1  >=1 free entry
rob_instr1_check_top  out  1  >=2 free entries
rob_is_empty  out  1  no valid entries
instr0_rob_tag, instr1_rob_tag  out  TAG_W  tags for this cycle's allocations
wb0_valid, wb1_valid  in  1  writeback completion
wb0_tag, wb1_tag  in  TAG_W  completing entry
br_recover  in  1  mispredict; squash entries younger than br_tag
br_tag  in  TAG_W  mispredicting branch tag
flush  in  1  squash all entries
recovery_no_copy  out  1  last recovery squashed nothing
recovery_target_rob_tag  out  TAG_W  last recovery tag
commit0_valid, commit1_valid  out  1  entry retiring this cycle
commit0_stale_rd, commit1_stale_rd  out  PRF_W  PRF to free (qualified by *_free)
commit0_free, commit1_free  out  1  commitN_valid & stale_rd_valid
commit0_rd_arf, commit1_rd_arf  out  ARF_W  retiring rd (for committed map)
commit0_rd_prf, commit1_rd_prf  out  PRF_W  retiring PRF
commit0_is_store, commit1_is_store  out  1  release store to memory

Behaviour:
- State: head, tail pointers, each TAG_W+1 bits with a wrap bit. count = tail-head (TAG_W+1 bits). Per entry: valid, done, payload.
- Reset: head=tail=0, all valid/done=0, recovery_no_copy=0, recovery_target_rob_tag=0. rob_is_empty=1, both check_top=1, all commit outputs 0.
- check_top: rob_instr0_check_top = count<=ROB_DEPTH-1. rob_instr1_check_top = count<=ROB_DEPTH-2. Both are combinational from registered count, and independent of same-cycle commit.
- Tags: instr0_rob_tag = tail[TAG_W-1:0]. instr1_rob_tag = (tail + instr0_req)[TAG_W-1:0]. Both are combinational.
- Allocation:
  - At the clock edge, write the requested slots, set valid=1 and done=0, and advance tail by instr0_req+instr1_req.
  - A request whose check_top is low is dropped. An instr1-only request uses tail.
- Completion: wbN_valid sets done on a valid entry at the clock edge. A writeback to an invalid entry is ignored. Both ports may hit simultaneously.
- Commit:
  - Combinational from registered state. commit0_valid = valid[head] & done[head]. commit1_valid = commit0_valid & valid[head+1] & done[head+1].
  - At the edge, the committed entries are invalidated and head advances by commit0_valid+commit1_valid.
  - Writeback done in cycle N gives commit visible in cycle N+1 at the earliest.
- Recovery (br_recover):
  - Tail becomes br_tag+1 with the wrap bit derived from head and br_tag. Entries between br_tag+1 and the old tail are invalidated.
  - Allocation in the same cycle is suppressed.
  - Commit and writeback in the same cycle still take effect for surviving entries.
  - recovery_target_rob_tag<=br_tag. recovery_no_copy<=(old tail==br_tag+1).
  - br_tag naming an invalid entry is illegal; the bench asserts it.
- Flush: highest priority. All valid=0, tail<=head+commits-this-cycle (commit outputs still retire), allocation suppressed, recovery_no_copy<=0.
- Priority: flush > br_recover > allocation. Commit and writeback are always honoured.
- Wrap-around: indices are taken modulo ROB_DEPTH. Full is count==ROB_DEPTH; empty is count==0.
- Asserting rst mid-operation returns all state to reset values immediately.

Test Plan:
- Reset, then instr0_req+instr1_req for 8 cycles (no writeback) -> tags 0..15 issued; after the 8th edge count=16, check_top0=0, check_top1=0, rob_is_empty=0.
- With count=15, a dual request -> slot0 allocated at tag 15 only; count=16; slot1 dropped.
- Allocate tags 0,1,2; wb tags 2 and 1 in cycle N, then tag 0 in cycle N+1 -> cycle N+1: no commit; cycle N+2: commit0 tag0 and commit1 tag1; cycle N+3: commit0 tag2; then rob_is_empty=1.
- Allocate 20 singles, committing each after writeback -> tags wrap 15->0, correct commit order; stale_rd freed only where stale_rd_valid=1.
- Entries at tags 3..9, br_recover with br_tag=5 plus a same-cycle dual request -> tail=6, entries 6..9 invalid, no allocation, recovery_no_copy=0, target=5. Repeat with br_tag=5 -> recovery_no_copy=1.
- flush while head entry is done, plus wb and alloc requests -> head entry commits, queue empty next cycle, later allocation restarts at the new head.
